// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared control constants for the multi-cycle multiplier/divider
package divider_pkg;

    // Default operand width; the iteration count equals the width.
    localparam int DIV_WIDTH = 32;

    // Control state encodings shared with the multiplier.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring signed/unsigned divider, one quotient bit per clock
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 div,
    input  logic                 sign,
    input  logic [0:WIDTH-1]     a,
    input  logic [0:WIDTH-1]     b,
    output logic                 working,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [0:2*WIDTH-1]   result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Operands in conventional descending order; numeric value is unchanged.
    logic [WIDTH-1:0] a_v;
    logic [WIDTH-1:0] b_v;
    assign a_v = a;
    assign b_v = b;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]       r_q, r_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     bmag_q, bmag_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 working_q, working_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 sa_in;
    logic                 sb_in;
    logic [WIDTH+1:0]     r_shift;
    logic [WIDTH+1:0]     diff;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;

    // Next-state logic: accept, shift-subtract iteration, sign fix-up and done pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        bmag_d    = bmag_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        result_d  = result_q;
        dbz_d     = 1'b0;

        sa_in   = a_v[WIDTH-1] & sign;
        sb_in   = b_v[WIDTH-1] & sign;
        // The quotient register starts out holding |a|; its MSB feeds R each step
        // while the new quotient bit enters at the LSB.
        r_shift = {r_q, q_q[WIDTH-1]};
        diff    = r_shift - {2'b00, bmag_q};
        q_fix   = (sa_q ^ sb_q) ? -q_q : q_q;
        r_fix   = sa_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (div) begin
                    sa_d   = sa_in;
                    sb_d   = sb_in;
                    q_d    = sa_in ? -a_v : a_v;
                    bmag_d = sb_in ? -b_v : b_v;
                    r_d    = '0;
                    cnt_d  = '0;
                    if (b_v == '0) begin
                        // Zero divisor skips the iteration entirely.
                        result_d = {{WIDTH{1'b1}}, a_v};
                        dbz_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                if (!diff[WIDTH+1]) begin
                    r_d = diff[WIDTH:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_shift[WIDTH:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = {q_fix, r_fix};
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        working_d = (state_d == ST_ITER) || (state_d == ST_FIX);
        done_d    = (state_d == ST_DONE);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            bmag_q    <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            working_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            bmag_q    <= bmag_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            working_q <= working_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            result_q  <= result_d;
        end
    end

    assign working     = working_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for the sequential divider
module tb_divider;

    logic        clk;
    logic        reset;
    logic        div;
    logic        sign;
    logic [0:31] a;
    logic [0:31] b;
    logic        working;
    logic        done;
    logic        div_by_zero;
    logic [0:63] result;

    int tests;
    int fails;

    divider dut (
        .clk         (clk),
        .reset       (reset),
        .div         (div),
        .sign        (sign),
        .a           (a),
        .b           (b),
        .working     (working),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations from one operation window.
    int          done_cyc;
    int          n_done;
    logic        saw_work;
    logic [63:0] res_done;
    logic        dbz_done;
    logic [63:0] res_end;
    logic        rst_work;
    logic        rst_done;
    logic [63:0] rst_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Start an operation and watch 40 cycles after the accept edge.
    // pulse_at: cycle in which a second start (9/3) is requested; rst_at: cycle in which reset is low.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                          input int pulse_at, input int rst_at);
        done_cyc = -1;
        n_done   = 0;
        saw_work = 1'b0;
        res_done = '0;
        dbz_done = 1'b0;
        rst_work = 1'bx;
        rst_done = 1'bx;
        rst_res  = 'x;
        a = av; b = bv; sign = sg; div = 1'b1;
        @(posedge clk);
        #1;
        div = 1'b0; a = '0; b = '0; sign = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                if (n_done == 0) begin
                    done_cyc = i;
                    res_done = result;
                    dbz_done = div_by_zero;
                end
                n_done++;
            end
            if (working) saw_work = 1'b1;
            if (i == rst_at + 1) begin
                rst_work = working;
                rst_done = done;
                rst_res  = result;
            end
            div   = (i == pulse_at);
            a     = (i == pulse_at) ? 32'd9 : 32'd0;
            b     = (i == pulse_at) ? 32'd3 : 32'd0;
            reset = (i != rst_at);
            @(posedge clk);
            #1;
        end
        div = 1'b0; reset = 1'b1;
        res_end = result;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0; div = 1'b0; sign = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_working", {63'd0, working}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        check("reset_result", result, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned 100 / 7
        run_op(32'd100, 32'd7, 1'b0, -1, -1);
        check("u100_7_cycle", 64'(done_cyc), 64'd34);
        check("u100_7_ndone", 64'(n_done), 64'd1);
        check("u100_7_result", res_done, {32'h0000000E, 32'h00000002});
        check("u100_7_dbz", {63'd0, dbz_done}, 64'd0);
        check("u100_7_working", {63'd0, saw_work}, 64'd1);
        check("u100_7_hold", res_end, {32'h0000000E, 32'h00000002});

        // Signed -7 / 2
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, -1, -1);
        check("s_m7_2_result", res_done, {32'hFFFFFFFD, 32'hFFFFFFFF});
        check("s_m7_2_cycle", 64'(done_cyc), 64'd34);

        // Signed overflow and its unsigned reinterpretation
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, -1);
        check("s_ovf_result", res_done, {32'h80000000, 32'h00000000});
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, -1, -1);
        check("u_ovf_result", res_done, {32'h00000000, 32'h80000000});

        // Divide by zero
        run_op(32'd5, 32'd0, 1'b0, -1, -1);
        check("dbz_cycle", 64'(done_cyc), 64'd1);
        check("dbz_flag", {63'd0, dbz_done}, 64'd1);
        check("dbz_result", res_done, {32'hFFFFFFFF, 32'h00000005});
        check("dbz_working", {63'd0, saw_work}, 64'd0);
        check("dbz_ndone", 64'(n_done), 64'd1);

        // Start while busy is ignored
        run_op(32'd100, 32'd7, 1'b0, 10, -1);
        check("busy_ndone", 64'(n_done), 64'd1);
        check("busy_cycle", 64'(done_cyc), 64'd34);
        check("busy_result", res_done, {32'h0000000E, 32'h00000002});

        // Reset mid-operation, then a fresh operation
        run_op(32'd100, 32'd7, 1'b0, -1, 12);
        check("midrst_working", {63'd0, rst_work}, 64'd0);
        check("midrst_done", {63'd0, rst_done}, 64'd0);
        check("midrst_result", rst_res, 64'd0);
        check("midrst_ndone", 64'(n_done), 64'd0);
        run_op(32'd50, 32'd5, 1'b0, -1, -1);
        check("after_rst_result", res_done, {32'd10, 32'd0});
        check("after_rst_cycle", 64'(done_cyc), 64'd34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
